// File: rtl/operand_entry_pkg.sv
// operand_entry_pkg: field encoding and sizing helpers for operand entry
package operand_entry_pkg;
  localparam int FIELD_W = 2;
  typedef enum logic [FIELD_W-1:0] {
    ENT_A  = 2'b00,
    ENT_B  = 2'b01,
    ENT_OP = 2'b10,
    ISSUE  = 2'b11
  } field_t;
  function automatic int cnt_w(input int n);
    return $clog2(n / 4 + 1);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a raw button, debounces both edges, pulses once per accepted press
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync    <= '0;
      level   <= 1'b0;
      cnt     <= '0;
      pulse_o <= 1'b0;
    end else begin
      sync    <= {sync[0], btn_i};
      pulse_o <= 1'b0;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level   <= sync[1];
        cnt     <= '0;
        pulse_o <= sync[1];
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/operand_entry.sv
// operand_entry: hex-digit operand, opcode and carry entry with valid/ready issue to the ALU
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int N          = 32,
  parameter int DEB_CYCLES = 500000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [3:0]         nibble_i,
  input  logic               push_i,
  input  logic               next_i,
  input  logic               clr_i,
  input  logic [3:0]         ope_i,
  input  logic               c_i,
  input  logic               ready_i,
  output logic [N-1:0]       A_o,
  output logic [N-1:0]       B_o,
  output logic [3:0]         ope_o,
  output logic               c_o,
  output logic               valid_o,
  output logic [N-1:0]       show_o,
  output logic [FIELD_W-1:0] state_o
);
  localparam int D  = N / 4;
  localparam int CW = cnt_w(N);
  field_t        state, state_n;
  logic [CW-1:0] cnt_a, cnt_b;
  logic          p_push, p_next, p_clr, clr, nxt, psh;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_push (.clk_i, .rst_ni, .btn_i(push_i), .pulse_o(p_push));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_next (.clk_i, .rst_ni, .btn_i(next_i), .pulse_o(p_next));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr  (.clk_i, .rst_ni, .btn_i(clr_i),  .pulse_o(p_clr));
  assign clr     = p_clr;
  assign nxt     = p_next & ~p_clr;
  assign psh     = p_push & ~p_next & ~p_clr;
  assign valid_o = state == ISSUE;
  assign state_o = state;
  assign show_o  = state == ENT_A  ? A_o :
                   state == ENT_B  ? B_o :
                   state == ENT_OP ? N'({c_i, ope_i}) : N'({c_o, ope_o});
  always_comb begin
    state_n = state;
    case (state)
      ENT_A:   state_n = nxt ? ENT_B : ENT_A;
      ENT_B:   state_n = nxt ? ENT_OP : ENT_B;
      ENT_OP:  state_n = clr ? ENT_B : nxt ? ISSUE : ENT_OP;
      default: state_n = ready_i ? ENT_A : clr ? ENT_OP : ISSUE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= ENT_A;
    else state <= state_n;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      A_o   <= '0;
      B_o   <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
      ope_o <= '0;
      c_o   <= 1'b0;
    end else begin
      if (state == ENT_A && clr) begin
        A_o   <= '0;
        cnt_a <= '0;
      end else if (state == ENT_A && psh && cnt_a != CW'(D)) begin
        A_o   <= cnt_a == '0 ? N'(nibble_i) : {A_o[N-5:0], nibble_i};
        cnt_a <= cnt_a + 1'b1;
      end else if (state == ISSUE && ready_i) cnt_a <= '0;
      if (state == ENT_B && clr) begin
        B_o   <= '0;
        cnt_b <= '0;
      end else if (state == ENT_B && psh && cnt_b != CW'(D)) begin
        B_o   <= cnt_b == '0 ? N'(nibble_i) : {B_o[N-5:0], nibble_i};
        cnt_b <= cnt_b + 1'b1;
      end else if (state == ISSUE && ready_i) cnt_b <= '0;
      if (state == ENT_OP && nxt) begin
        ope_o <= ope_i;
        c_o   <= c_i;
      end
    end
  end
endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry: directed scoreboard bench for operand_entry
module tb_operand_entry;
  localparam int N   = 32;
  localparam int DEB = 4;
  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic [3:0]   nibble_i = '0;
  logic         push_i = 1'b0, next_i = 1'b0, clr_i = 1'b0;
  logic [3:0]   ope_i = '0;
  logic         c_i = 1'b0, ready_i = 1'b0;
  logic [N-1:0] A_o, B_o, show_o;
  logic [3:0]   ope_o;
  logic         c_o, valid_o;
  logic [1:0]   state_o;
  logic [N-1:0] exp_q[$];
  int           total = 0;
  int           bad = 0;
  operand_entry #(.N(N), .DEB_CYCLES(DEB)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .nibble_i(nibble_i), .push_i(push_i), .next_i(next_i),
    .clr_i(clr_i), .ope_i(ope_i), .c_i(c_i), .ready_i(ready_i), .A_o(A_o), .B_o(B_o),
    .ope_o(ope_o), .c_o(c_o), .valid_o(valid_o), .show_o(show_o), .state_o(state_o)
  );
  always #5 clk = ~clk;
  task automatic want(input logic [N-1:0] v);
    exp_q.push_back(v);
  endtask
  task automatic chk(input string tag, input logic [N-1:0] obs);
    logic [N-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask
  task automatic press(input logic [2:0] m);
    @(negedge clk);
    {clr_i, next_i, push_i} = m;
    repeat (DEB + 3) @(negedge clk);
    {clr_i, next_i, push_i} = '0;
    repeat (DEB + 3) @(negedge clk);
  endtask
  task automatic dig(input logic [3:0] n);
    nibble_i = n;
    press(3'b001);
  endtask
  initial begin
    logic [3:0]   digs [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD};
    logic [N-1:0] ma;
    int           hi;
    repeat (2) @(negedge clk);
    want(0); chk("rst_state", N'(state_o));
    want(0); chk("rst_valid", N'(valid_o));
    want(0); chk("rst_A", A_o);
    want(0); chk("rst_B", B_o);
    want(0); chk("rst_ope", N'(ope_o));
    want(0); chk("rst_c", N'(c_o));
    rst_ni = 1'b1;
    dig(4'h5); press(3'b010);
    dig(4'h3); press(3'b010);
    ope_i = 4'h2; c_i = 1'b1;
    press(3'b010);
    want(1); chk("pre_rst_valid", N'(valid_o));
    want(3); chk("pre_rst_state", N'(state_o));
    rst_ni = 1'b0;
    @(negedge clk);
    want(0); chk("issue_rst_valid", N'(valid_o));
    want(0); chk("issue_rst_state", N'(state_o));
    want(0); chk("issue_rst_A", A_o);
    want(0); chk("issue_rst_B", B_o);
    rst_ni = 1'b1;
    ma = '0;
    for (int i = 0; i < 8; i++) begin
      dig(digs[i]);
      ma = (i == 0) ? N'(digs[i]) : {ma[N-5:0], digs[i]};
    end
    want(ma); chk("eight_digits_A", A_o);
    want(32'h1234ABCD); chk("eight_digits_show", show_o);
    dig(4'hF);
    want(32'h1234ABCD); chk("ninth_digit_ignored", A_o);
    press(3'b100);
    want(0); chk("clr_A", A_o);
    nibble_i = 4'h6;
    for (int i = 0; i < 5; i++) begin
      push_i = 1'b1; repeat (2) @(negedge clk);
      push_i = 1'b0; repeat (2) @(negedge clk);
    end
    push_i = 1'b1;
    repeat (6) @(negedge clk);
    want(0); chk("bounce_before_effect", A_o);
    @(negedge clk);
    want(6); chk("bounce_effect_at_7", A_o);
    repeat (3) @(negedge clk);
    push_i = 1'b0;
    repeat (DEB + 3) @(negedge clk);
    want(6); chk("bounce_one_shift", A_o);
    press(3'b100);
    dig(4'h5);
    want(5); chk("txn_A", A_o);
    press(3'b010);
    dig(4'h3);
    want(3); chk("txn_B", B_o);
    press(3'b010);
    ope_i = 4'h2; c_i = 1'b1;
    @(negedge clk);
    want(2); chk("op_state", N'(state_o));
    want(32'h12); chk("op_show_live", show_o);
    press(3'b010);
    want(1); chk("issue_valid", N'(valid_o));
    want(5); chk("issue_A", A_o);
    want(3); chk("issue_B", B_o);
    want(2); chk("issue_ope", N'(ope_o));
    want(1); chk("issue_c", N'(c_o));
    ope_i = 4'h7; c_i = 1'b0;
    @(negedge clk);
    want(32'h12); chk("issue_show_latched", show_o);
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (valid_o) hi++;
    end
    want(10); chk("valid_held_no_ready", N'(hi));
    ready_i = 1'b1;
    @(negedge clk);
    want(0); chk("xfer_valid", N'(valid_o));
    want(0); chk("xfer_state", N'(state_o));
    ready_i = 1'b0;
    dig(4'h7);
    want(7); chk("fresh_A", A_o);
    want(3); chk("B_kept", B_o);
    press(3'b010); press(3'b010); press(3'b010);
    want(1); chk("issue2_valid", N'(valid_o));
    press(3'b100);
    want(0); chk("abort_valid", N'(valid_o));
    want(2); chk("abort_state", N'(state_o));
    ready_i = 1'b1;
    press(3'b010);
    want(0); chk("ready_high_xfer_state", N'(state_o));
    ready_i = 1'b0;
    dig(4'h9);
    want(9); chk("A9", A_o);
    press(3'b110);
    want(0); chk("clr_beats_next_A", A_o);
    want(0); chk("clr_beats_next_state", N'(state_o));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/operand_entry.md
# operand_entry

Front-end input block for the board-level ALU demo: the input-side counterpart of the result display path. Collects two N-bit operands hex digit by hex digit from the slide switches via push buttons, then the operation code and carry-in, and presents them to the ALU with a valid/ready handshake. It also outputs the field currently being edited so the existing seven-segment decoder chain can echo the entry.

## Interface
- N, 32, operand width; multiple of 4, ≥ 8
- DEB_CYCLES, 500000, consecutive stable cycles required to accept a button level change
- clk_i  in  1  system clock
- rst_ni  in  1  reset; synchronous, active-low
- nibble_i  in  4  hex digit from switches
- push_i  in  1  raw button: shift digit into current operand
- next_i  in  1  raw button: advance to next field / issue
- clr_i  in  1  raw button: clear current operand / abort issue
- ope_i  in  4  operation code switches
- c_i  in  1  carry-in switch
- ready_i  in  1  ALU side accepts operands
- A_o  out  N  operand A
- B_o  out  N  operand B
- ope_o  out  4  latched operation code
- c_o  out  1  latched carry-in
- valid_o  out  1  operands/operation valid
- show_o  out  N  value for display chain
- state_o  out  2  current field: 00 ENT_A, 01 ENT_B, 10 ENT_OP, 11 ISSUE

## Operation
- Each raw button: 2-flop synchronizer, then debouncer; accepted level changes only after DEB_CYCLES consecutive identical synchronized samples; one-cycle internal pulse on accepted low→high. Releases are debounced the same way; holding gives one pulse.
- Pulse priority in the same cycle: clr > next > push; lower-priority pulses that cycle are dropped.
- ENT_A / ENT_B (operand X = A or B, digit counter cnt, 0..N/4):
  - push, cnt==0: X ← zero-extended nibble_i, cnt ← 1 (fresh entry discards old value).
  - push, 0<cnt<N/4: X ← {X[N-5:0], nibble_i}, cnt+1.
  - push, cnt==N/4: ignored (saturating).
  - clr: X ← 0, cnt ← 0, stay.
  - next: ENT_A→ENT_B, ENT_B→ENT_OP; counters unchanged.
- ENT_OP: push ignored; clr → ENT_B (cnt_B kept); next: ope_o ← ope_i, c_o ← c_i, → ISSUE.
- ISSUE: valid_o=1; transfer on valid_o && ready_i → ENT_A, cnt_A ← 0, cnt_B ← 0; A_o, B_o, ope_o, c_o hold until overwritten. clr (no transfer that cycle) → ENT_OP. push/next ignored. Transfer takes priority over clr in the same cycle.
- show_o: ENT_A → A_o; ENT_B → B_o; ENT_OP → zero-extended {c_i, ope_i} (live); ISSUE → zero-extended {c_o, ope_o}.
- Reset (any state, including mid-issue or mid-debounce): A_o=B_o=0, ope_o=0, c_o=0, valid_o=0, state_o=00, counters 0, debouncer accepted levels low.

## Timing
- Raw button rising and held from cycle t: internal pulse at cycle t+2+DEB_CYCLES; register effect visible on outputs at t+3+DEB_CYCLES.
- valid_o decoded from state register: high the cycle after the accepting next pulse, low the cycle after transfer or abort.
- ready_i held high: valid_o high exactly one cycle per issue.
- A_o, B_o, ope_o, c_o stable for the whole time valid_o is high.
- show_o combinational from registers and ope_i/c_i; no added latency.

## Structure
- Package operand_entry_pkg: state encoding constants (ENT_A, ENT_B, ENT_OP, ISSUE), field-code width, digit-count width function of N.
- Sub-module btn_debounce (sync + debounce + rise pulse, parameter DEB_CYCLES), instantiated three times.
- Top: FSM, operand shift registers, digit counters, show_o mux.

## Test plan
- DEB_CYCLES=4 throughout. Reset asserted while in ISSUE with valid_o=1 → next edge: valid_o=0, state_o=00, A_o=B_o=0.
- Pushes 1,2,3,4,A,B,C,D in ENT_A → A_o=0x1234ABCD, show_o=0x1234ABCD; 9th push of F → A_o unchanged.
- push_i toggling every 2 cycles for 20 cycles then stable high 10 cycles → exactly one shift; timing of effect = stable-start + 7.
- A=0x5, next, B=0x3, next, ope_i=0x2, c_i=1, next → valid_o=1, A_o=5, B_o=3, ope_o=2, c_o=1, show_o=0x12; ready_i low 10 cycles → valid_o held; ready_i high → one-cycle transfer, state_o=00 next cycle.
- After transfer, push 7 → A_o=0x7 (not 0x57), B_o still 0x3.
- clr in ISSUE → valid_o=0 next cycle, state_o=10; clr and next pulsed together in ENT_A with A_o=0x9 → A_o=0, state_o stays 00.
